// File: rtl/cond_unit.sv
// Condition/flag stage: holds the NZCV register, evaluates the instruction condition
// against it, gates the decoder write/PC controls and counts condition-failed instructions.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             flush,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pc_s,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags,
    output logic             carry_in,
    output logic [CNT_W-1:0] skip_cnt
);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             condPass;
    logic             flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = flags_q;

    // Condition is judged only on the registered flags; there is no bypass from alu_flags.
    always_comb begin
        condPass = 1'b0;
        unique case (cond)
            4'b0000: condPass = flagZ;
            4'b0001: condPass = ~flagZ;
            4'b0010: condPass = flagC;
            4'b0011: condPass = ~flagC;
            4'b0100: condPass = flagN;
            4'b0101: condPass = ~flagN;
            4'b0110: condPass = flagV;
            4'b0111: condPass = ~flagV;
            4'b1000: condPass = flagC & ~flagZ;
            4'b1001: condPass = ~flagC | flagZ;
            4'b1010: condPass = (flagN == flagV);
            4'b1011: condPass = (flagN != flagV);
            4'b1100: condPass = ~flagZ & (flagN == flagV);
            4'b1101: condPass = flagZ | (flagN != flagV);
            4'b1110: condPass = 1'b1;
            4'b1111: condPass = 1'b0;
            default: condPass = 1'b0;
        endcase
    end

    assign cond_ex   = condPass & ~flush;
    assign pc_src    = pc_s & cond_ex;
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;
    assign flags     = flags_q;
    assign carry_in  = flags_q[1];
    assign skip_cnt  = skip_q;

    // NZ and CV halves update independently; a squashed instruction is not a skip.
    always_comb begin
        flags_d = flags_q;
        skip_d  = skip_q;
        if (en && cond_ex) begin
            if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
        end
        if (en && !flush && !condPass && (skip_q != {CNT_W{1'b1}})) begin
            skip_d = skip_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= 4'b0000;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            skip_q  <= skip_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a behavioural NZCV/skip model compared every
// negative edge, plus directed literal checks and a randomized phase.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0, flush = 1'b0;
    logic [3:0] cond = 4'b0, alu_flags = 4'b0;
    logic [1:0] flag_w = 2'b0;
    logic       pc_s = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;

    logic        pc_src, reg_write, mem_write, cond_ex, carry_in;
    logic [3:0]  flags;
    logic [15:0] skip_cnt;
    logic        pc_src4, reg_write4, mem_write4, cond_ex4, carry_in4;
    logic [3:0]  flags4;
    logic [3:0]  skip_cnt4;

    int checks = 0;
    int errors = 0;

    logic [3:0] flagsM;
    int         cntM16;
    int         cntM4;

    cond_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pc_s(pc_s), .reg_w(reg_w),
        .mem_w(mem_w), .no_write(no_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_write(mem_write), .cond_ex(cond_ex), .flags(flags), .carry_in(carry_in),
        .skip_cnt(skip_cnt)
    );

    cond_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pc_s(pc_s), .reg_w(reg_w),
        .mem_w(mem_w), .no_write(no_write), .pc_src(pc_src4), .reg_write(reg_write4),
        .mem_write(mem_write4), .cond_ex(cond_ex4), .flags(flags4), .carry_in(carry_in4),
        .skip_cnt(skip_cnt4)
    );

    always #5 clk = ~clk;

    // Conditions come in pairs: odd codes are the negation of the even code below them,
    // except 1111 which is never.
    function automatic logic condEval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state advances on the same edge as the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flagsM = 4'b0;
            cntM16 = 0;
            cntM4  = 0;
        end else begin
            logic pass;
            pass = condEval(cond, flagsM);
            if (en && !flush && !pass) begin
                if (cntM16 < 65535) cntM16 = cntM16 + 1;
                if (cntM4 < 15) cntM4 = cntM4 + 1;
            end
            if (en && pass && !flush) begin
                if (flag_w[1]) flagsM[3:2] = alu_flags[3:2];
                if (flag_w[0]) flagsM[1:0] = alu_flags[1:0];
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            logic ex;
            ex = condEval(cond, flagsM) && !flush;
            checkOutput("cond_ex", {31'b0, cond_ex}, {31'b0, ex});
            checkOutput("pc_src", {31'b0, pc_src}, {31'b0, pc_s && ex});
            checkOutput("reg_write", {31'b0, reg_write}, {31'b0, reg_w && ex && !no_write});
            checkOutput("mem_write", {31'b0, mem_write}, {31'b0, mem_w && ex});
            checkOutput("flags", {28'b0, flags}, {28'b0, flagsM});
            checkOutput("carry_in", {31'b0, carry_in}, {31'b0, flagsM[1]});
            checkOutput("skip_cnt", {16'b0, skip_cnt}, cntM16);
            checkOutput("skip_cnt4", {28'b0, skip_cnt4}, cntM4);
            checkOutput("flags4", {28'b0, flags4}, {28'b0, flagsM});
        end
    end

    task automatic applyStimulus(input logic e, input logic fl, input logic [3:0] c,
                                 input logic [3:0] af, input logic [1:0] fw,
                                 input logic ps, input logic rw, input logic mw,
                                 input logic nw);
        @(posedge clk);
        #1;
        en = e; flush = fl; cond = c; alu_flags = af; flag_w = fw;
        pc_s = ps; reg_w = rw; mem_w = mw; no_write = nw;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'b1110, 4'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse entirely between two rising edges.
    task automatic resetPulse(input logic doChecks);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        cond = 4'b0000;
        #1;
        if (doChecks) begin
            checkOutput("rst_flags", {28'b0, flags}, 32'h0);
            checkOutput("rst_skip", {16'b0, skip_cnt}, 32'h0);
            checkOutput("rst_carry", {31'b0, carry_in}, 32'h0);
            checkOutput("rst_eq", {31'b0, cond_ex}, 32'h0);
        end
        cond = 4'b0001;
        #1;
        if (doChecks) checkOutput("rst_ne", {31'b0, cond_ex}, 32'h1);
        reset_n = 1'b1;
    endtask

    initial begin
        #12 reset_n = 1'b1;
        checkOutput("init_flags", {28'b0, flags}, 32'h0);
        checkOutput("init_skip", {16'b0, skip_cnt}, 32'h0);

        // Gating: EQ fails with Z=0, nothing written, one skip.
        applyStimulus(1, 0, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0);
        applyStimulus(1, 0, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0);
        @(negedge clk);
        checkOutput("gate_pc", {31'b0, pc_src}, 32'h0);
        checkOutput("gate_reg", {31'b0, reg_write}, 32'h0);
        checkOutput("gate_mem", {31'b0, mem_write}, 32'h0);
        idle();
        @(negedge clk);
        checkOutput("gate_skip", {16'b0, skip_cnt}, 32'h1);
        checkOutput("gate_flags", {28'b0, flags}, 32'h0);

        // CMP: flags written, register write suppressed.
        applyStimulus(1, 0, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 1);
        @(negedge clk);
        checkOutput("cmp_reg", {31'b0, reg_write}, 32'h0);
        idle();
        @(negedge clk);
        checkOutput("cmp_flags", {28'b0, flags}, 32'h6);

        // Partial update: logic op leaves C,V alone.
        applyStimulus(1, 0, 4'b1110, 4'b1001, 2'b10, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        checkOutput("part_flags", {28'b0, flags}, 32'hA);
        checkOutput("part_carry", {31'b0, carry_in}, 32'h1);

        // Flush of a failing instruction is not counted; stall freezes flags.
        applyStimulus(1, 1, 4'b1111, 4'b0000, 2'b11, 1, 1, 1, 0);
        idle();
        @(negedge clk);
        checkOutput("flush_skip", {16'b0, skip_cnt}, 32'h1);
        applyStimulus(0, 0, 4'b1110, 4'b0101, 2'b11, 0, 1, 0, 0);
        @(negedge clk);
        checkOutput("stall_reg", {31'b0, reg_write}, 32'h1);
        idle();
        @(negedge clk);
        checkOutput("stall_flags", {28'b0, flags}, 32'hA);

        // Asynchronous reset from flags 1111.
        applyStimulus(1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        checkOutput("pre_rst_flags", {28'b0, flags}, 32'hF);
        resetPulse(1'b1);

        // Condition sweep over all flag values and codes.
        for (int v = 0; v < 16; v++) begin
            applyStimulus(1, 0, 4'b1110, 4'(v), 2'b11, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                applyStimulus(0, 0, 4'(c), 4'b0000, 2'b00, 1, 1, 1, 0);
                if (c == 15) begin
                    @(negedge clk);
                    checkOutput("never", {31'b0, cond_ex}, 32'h0);
                end
            end
        end

        // Saturation of the narrow counter.
        resetPulse(1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 4'b1111, 4'b0000, 2'b11, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        checkOutput("sat_skip4", {28'b0, skip_cnt4}, 32'hF);
        checkOutput("sat_skip16", {16'b0, skip_cnt}, 32'd20);
        applyStimulus(1, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        checkOutput("sat_hold4", {28'b0, skip_cnt4}, 32'hF);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) resetPulse(1'b0);
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                          4'($urandom), 4'($urandom), 2'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
